// File: rtl/crc32_calc_top.sv
// PNG chunk CRC-32 engine: IHDR CRC from picture size, then IDAT CRC over a streamed payload.
// Optional IHDR stage is enabled by defining CRC32_IHDR_EN.
module crc32_calc_top #(
    parameter int DATA_WD     = 32,
    parameter int NUM_WD      = 2,
    parameter int SIZE_PIC_WD = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [SIZE_PIC_WD-1:0] w_i,
    input  logic [SIZE_PIC_WD-1:0] h_i,
    input  logic                   start_i,
    input  logic                   val_i,
    input  logic [DATA_WD-1:0]     dat_i,
    input  logic [NUM_WD-1:0]      num_i,
    input  logic                   lst_i,
    output logic                   done_o,
    output logic                   val_o,
    output logic [DATA_WD-1:0]     dat_o
);

    localparam logic [DATA_WD-1:0] POLY     = 32'hEDB8_8320;
    localparam logic [DATA_WD-1:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [DATA_WD-1:0] TAG_IDAT = 32'h4944_4154;

    typedef enum logic [1:0] {
        S_IDLE,
        S_IHDR,
        S_IDAT_INIT,
        S_DAT
    } state_t;

    state_t             state;
    logic [DATA_WD-1:0] crc_q;
    logic [DATA_WD-1:0] crc_next;
    logic [DATA_WD-1:0] upd_base;
    logic [DATA_WD-1:0] upd_dat;
    logic [NUM_WD-1:0]  upd_num;
    logic [DATA_WD-1:0] crc_chain [4];

`ifdef CRC32_IHDR_EN
    localparam logic [DATA_WD-1:0] TAG_IHDR = 32'h4948_4452;
    localparam logic [DATA_WD-1:0] IHDR_TAIL = 32'h0802_0000;
    logic [SIZE_PIC_WD-1:0] w_q;
    logic [SIZE_PIC_WD-1:0] h_q;
    logic [2:0]             cnt;
`else
    logic unused_pic;
    assign unused_pic = ^{w_i, h_i};
`endif

    // One reflected CRC-32 byte step; the loop unrolls into the XOR network.
    function automatic logic [DATA_WD-1:0] crc_byte(input logic [DATA_WD-1:0] crc,
                                                    input logic [7:0]         b);
        logic [DATA_WD-1:0] c;
        c = crc ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
        end
        return c;
    endfunction

    // NOTE: every signal gets a default at the top so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        upd_base = crc_q;
        upd_dat  = dat_i;
        upd_num  = num_i;
        case (state)
            S_IDAT_INIT: begin
                upd_base = CRC_INIT;
                upd_dat  = TAG_IDAT;
                upd_num  = '1;
            end
`ifdef CRC32_IHDR_EN
            S_IHDR: begin
                upd_num = '1;
                case (cnt)
                    3'd0:    upd_dat = TAG_IHDR;
                    3'd1:    upd_dat = w_q;
                    3'd2:    upd_dat = h_q;
                    3'd3:    upd_dat = IHDR_TAIL;
                    default: begin
                        upd_dat = '0;
                        upd_num = '0;
                    end
                endcase
            end
`endif
            default: ;
        endcase

        // First byte on the wire sits in the top byte lane.
        crc_chain[0] = crc_byte(upd_base,     upd_dat[31:24]);
        crc_chain[1] = crc_byte(crc_chain[0], upd_dat[23:16]);
        crc_chain[2] = crc_byte(crc_chain[1], upd_dat[15:8]);
        crc_chain[3] = crc_byte(crc_chain[2], upd_dat[7:0]);
        crc_next     = crc_chain[upd_num];
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state  <= S_IDLE;
            crc_q  <= CRC_INIT;
            val_o  <= 1'b0;
            done_o <= 1'b0;
            dat_o  <= '0;
`ifdef CRC32_IHDR_EN
            w_q    <= '0;
            h_q    <= '0;
            cnt    <= '0;
`endif
        end else begin
            val_o  <= 1'b0;
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        crc_q <= CRC_INIT;
`ifdef CRC32_IHDR_EN
                        w_q   <= w_i;
                        h_q   <= h_i;
                        cnt   <= '0;
                        state <= S_IHDR;
`else
                        state <= S_IDAT_INIT;
`endif
                    end
                end
`ifdef CRC32_IHDR_EN
                S_IHDR: begin
                    crc_q <= crc_next;
                    cnt   <= cnt + 3'd1;
                    if (cnt == 3'd4) begin
                        val_o <= 1'b1;
                        dat_o <= ~crc_next;
                        state <= S_IDAT_INIT;
                    end
                end
`endif
                S_IDAT_INIT: begin
                    crc_q <= crc_next;
                    state <= S_DAT;
                end
                S_DAT: begin
                    if (val_i) begin
                        crc_q <= crc_next;
                        if (lst_i) begin
                            val_o  <= 1'b1;
                            done_o <= 1'b1;
                            dat_o  <= ~crc_next;
                            state  <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc32_calc_top.sv
// Self-checking bench for crc32_calc_top: scoreboard of expected CRC results against a bitwise CRC-32 model.
// Covers the IHDR stage when CRC32_IHDR_EN is defined.
module tb_crc32_calc_top;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] w_i;
    logic [31:0] h_i;
    logic        start_i;
    logic        val_i;
    logic [31:0] dat_i;
    logic [1:0]  num_i;
    logic        lst_i;
    logic        done_o;
    logic        val_o;
    logic [31:0] dat_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic        done;
        logic [31:0] crc;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  pay[$];
    logic [31:0] last_crc = '0;

`ifdef CRC32_IHDR_EN
    localparam int READY_WAIT = 6;
`else
    localparam int READY_WAIT = 1;
`endif

    crc32_calc_top dut (
        .clk     (clk),
        .rstn    (rstn),
        .w_i     (w_i),
        .h_i     (h_i),
        .start_i (start_i),
        .val_i   (val_i),
        .dat_i   (dat_i),
        .num_i   (num_i),
        .lst_i   (lst_i),
        .done_o  (done_o),
        .val_o   (val_o),
        .dat_o   (dat_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_ref(input logic [7:0] bytes[$]);
        logic [31:0] c = 32'hFFFF_FFFF;
        foreach (bytes[i]) begin
            c = c ^ {24'h0, bytes[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every val_o/done_o pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (val_o || done_o) begin
            if (sb.size() == 0) begin
                check("unexpected_out", {30'h0, val_o, done_o}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.tag, "_val"},  {31'h0, val_o},  32'h1);
                check({e.tag, "_done"}, {31'h0, done_o}, {31'h0, e.done});
                check({e.tag, "_crc"},  dat_o,           e.crc);
                last_crc = e.crc;
            end
        end
    end

    // Pulses start_i and leaves the bench positioned so the next edge is the first DAT cycle.
    task automatic start_frame(input string tag, input logic [31:0] w, input logic [31:0] h,
                               input bit early);
`ifdef CRC32_IHDR_EN
        logic [7:0] ih[$];
        exp_t e;
        ih = {8'h49, 8'h48, 8'h44, 8'h52, w[31:24], w[23:16], w[15:8], w[7:0],
              h[31:24], h[23:16], h[15:8], h[7:0], 8'h08, 8'h02, 8'h00, 8'h00, 8'h00};
        e.tag  = {tag, "_ihdr"};
        e.done = 1'b0;
        e.crc  = crc_ref(ih);
        sb.push_back(e);
`endif
        pay     = {8'h49, 8'h44, 8'h41, 8'h54};
        w_i     = w;
        h_i     = h;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        w_i     = 32'hDEAD_BEEF;
        h_i     = 32'hDEAD_BEEF;
        if (early) begin
            val_i = 1'b1; lst_i = 1'b1; num_i = 2'd3; dat_i = 32'hFFFF_FFFF;
            tick();
            val_i = 1'b0; lst_i = 1'b0;
            repeat (READY_WAIT - 1) tick();
        end else begin
            repeat (READY_WAIT) tick();
        end
    endtask

    task automatic send_word(input string tag, input logic [31:0] d, input logic [1:0] n,
                             input logic l, input logic st);
        val_i   = 1'b1;
        dat_i   = d;
        num_i   = n;
        lst_i   = l;
        start_i = st;
        for (int k = 0; k <= int'(n); k++) pay.push_back(d[31-8*k -: 8]);
        if (l) begin
            exp_t e;
            e.tag  = tag;
            e.done = 1'b1;
            e.crc  = crc_ref(pay);
            sb.push_back(e);
        end
        tick();
        val_i   = 1'b0;
        lst_i   = 1'b0;
        start_i = 1'b0;
        dat_i   = 32'h0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            check({tag, "_timeout"}, sb.size(), 32'h0);
            sb.delete();
        end
    endtask

    logic [31:0] words [10] = '{32'h0102_0304, 32'hA5B6_0000, 32'h7F00_0000, 32'hCAFE_BA00,
                                32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC, 32'hDDEE_0000,
                                32'hF0E1_D200, 32'h8000_0001};
    logic [1:0]  nums  [10] = '{2'd3, 2'd1, 2'd0, 2'd2, 2'd3, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};

    initial begin
        logic [7:0] kat[$];
        rstn = 1'b1; start_i = 1'b0; val_i = 1'b0; lst_i = 1'b0;
        dat_i = '0; num_i = '0; w_i = '0; h_i = '0;

        repeat (5) tick();
        check("rst_val",  {31'h0, val_o},  32'h0);
        check("rst_done", {31'h0, done_o}, 32'h0);
        check("rst_dat",  dat_o,           32'h0);
        rstn = 1'b0;
        tick();

        kat = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        check("model_kat", crc_ref(kat), 32'hCBF4_3926);

        // Frame 1: 1x1 picture, single-byte payload with junk in the unused lanes.
        start_frame("f1", 32'd1, 32'd1, 1'b0);
`ifdef CRC32_IHDR_EN
        check("ihdr_1x1_const", last_crc, 32'h9077_53DE);
`endif
        send_word("f1", 32'h00A5_A5A5, 2'd0, 1'b1, 1'b0);
        wait_drain("f1");
        repeat (3) tick();
        check("dat_hold", dat_o, last_crc);

        // Frame 2: early data word, ten mixed-length words, stray start_i mid-payload.
        start_frame("f2", 32'd640, 32'd480, 1'b1);
        for (int i = 0; i < 10; i++)
            send_word("f2", words[i], nums[i], (i == 9), (i == 4));
        wait_drain("f2");

        // Frame 3: reset after three words aborts with no output.
        start_frame("f3", 32'd5, 32'd9, 1'b0);
        for (int i = 0; i < 3; i++) send_word("f3", words[i], 2'd3, 1'b0, 1'b0);
        rstn = 1'b1;
        tick();
        tick();
        check("midrst_dat", dat_o, 32'h0);
        check("midrst_val", {31'h0, val_o}, 32'h0);
        rstn = 1'b0;
        repeat (4) tick();

        // Frame 4: fresh frame with random words after the abort.
        start_frame("f4", 32'd3, 32'd7, 1'b0);
        for (int i = 0; i < 6; i++)
            send_word("f4", $urandom, 2'($urandom_range(0, 3)), (i == 5), 1'b0);
        wait_drain("f4");

        // Frame 5: back-to-back single full word.
        start_frame("f5", 32'h0001_0000, 32'h0000_0100, 1'b0);
        send_word("f5", 32'h4142_4344, 2'd3, 1'b1, 1'b0);
        wait_drain("f5");
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
